writeback_stage: RTL and testbench

Final pipeline stage of the vector ASIP, directly downstream of the memory stage. It accepts each instruction leaving execute/memory and waits on multi-cycle memory operations through the memory stage's `mem_finished` handshake. It selects the write-back source (ALU result or memory read data) and drives the scalar and vector register-file write ports one cycle later. It also generates the pipeline stall, a restart pulse for the memory stage's read/write sequencers, and a sticky timeout error.

---
 rtl/asip_wb_pkg.sv | 13 +
 rtl/writeback_stage_mem_wait.sv | 85 ++++++++
 rtl/writeback_stage.sv | 100 ++++++++++
 tb/tb_writeback_stage.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/asip_wb_pkg.sv
// Shared types and constants for the vector ASIP write-back stage.
package asip_wb_pkg;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MEM_WAIT = 1'b1
  } wb_state_t;

  localparam logic OP_SCALAR   = 1'b0;
  localparam logic OP_VECTOR   = 1'b1;
  localparam int   DEF_TIMEOUT = 64;

endpackage

// File: rtl/writeback_stage_mem_wait.sv
// Purpose: sequences memory ops (restart pulse, capture, timeout) and drives the pipeline stall.
// Latency: restart pulse one cycle after accept; earliest capture the cycle after that.
// Backpressure: stall held from mem-op accept until capture or timeout; ALU ops never stall.
module mem_wait_fsm
  import asip_wb_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic valid_i,
  input  logic mem_op,
  input  logic mem_finished,
  output logic accept_alu,
  output logic accept_mem,
  output logic capture,
  output logic timeout,
  output logic stall,
  output logic mem_rst,
  output logic err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  wb_state_t     state, state_nxt;
  logic [CW-1:0] cnt;
  logic          mem_rst_q;
  logic          err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // mem_finished during the restart cycle still reflects the previous op.
  always_comb begin
    state_nxt  = state;
    accept_alu = 1'b0;
    accept_mem = 1'b0;
    capture    = 1'b0;
    timeout    = 1'b0;
    stall      = 1'b0;
    case (state)
      IDLE: begin
        if (valid_i && mem_op) begin
          accept_mem = 1'b1;
          stall      = 1'b1;
          state_nxt  = MEM_WAIT;
        end else if (valid_i) begin
          accept_alu = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (mem_finished && !mem_rst_q) begin
          capture   = 1'b1;
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          timeout   = 1'b1;
          state_nxt = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_rst_q <= 1'b0;
      cnt       <= '0;
      err_q     <= 1'b0;
    end else begin
      mem_rst_q <= accept_mem;
      if (accept_mem)            cnt <= '0;
      else if (state == MEM_WAIT) cnt <= cnt + CW'(1);
      err_q <= err_q | timeout;
    end
  end

  assign mem_rst = mem_rst_q;
  assign err     = err_q;

endmodule

// File: rtl/writeback_stage.sv
// Purpose: final ASIP stage; selects ALU or memory data and drives scalar/vector register-file writes.
// Latency: ALU op written 1 cycle after accept; memory op 1 cycle after the capture edge.
// Backpressure: stall_o holds upstream while a memory op is outstanding.
module writeback_stage
  import asip_wb_pkg::*;
#(
  parameter int I       = 20,
  parameter int L       = 8,
  parameter int R       = 4,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid_i,
  input  logic           op_type,
  input  logic           mem_read,
  input  logic           mem_write,
  input  logic           reg_write,
  input  logic [R-1:0]   rd_addr,
  input  logic [L-1:0]   aluResultS,
  input  logic [I*L-1:0] aluResultV,
  input  logic           mem_finished,
  input  logic [L-1:0]   scalar_output,
  input  logic [I*L-1:0] vector_output,
  output logic           stall_o,
  output logic           mem_rst_o,
  output logic           we_sca_o,
  output logic           we_vec_o,
  output logic [R-1:0]   wr_addr_o,
  output logic [L-1:0]   wd_sca_o,
  output logic [I*L-1:0] wd_vec_o,
  output logic           retire_o,
  output logic           err_o
);

  typedef struct packed {
    logic         wr;
    logic         op;
    logic [R-1:0] addr;
  } wb_tag_t;

  logic           accept_alu, accept_mem, capture, timeout;
  logic           wb_vld;
  wb_tag_t        wb_tag, pend_tag;
  logic [L-1:0]   wd_sca_dat;
  logic [I*L-1:0] wd_vec_dat;

  mem_wait_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
    .clk          (clk),
    .rst          (rst),
    .valid_i      (valid_i),
    .mem_op       (mem_read | mem_write),
    .mem_finished (mem_finished),
    .accept_alu   (accept_alu),
    .accept_mem   (accept_mem),
    .capture      (capture),
    .timeout      (timeout),
    .stall        (stall_o),
    .mem_rst      (mem_rst_o),
    .err          (err_o)
  );

  // Only the port being written is updated; the other keeps its last data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_vld     <= 1'b0;
      wb_tag     <= '0;
      pend_tag   <= '0;
      wd_sca_dat <= '0;
      wd_vec_dat <= '0;
    end else begin
      wb_vld <= accept_alu | capture;
      if (accept_mem)
        pend_tag <= '{wr: reg_write & mem_read, op: op_type, addr: rd_addr};
      if (accept_alu) begin
        wb_tag <= '{wr: reg_write, op: op_type, addr: rd_addr};
        if (op_type == OP_SCALAR) wd_sca_dat <= aluResultS;
        else                      wd_vec_dat <= aluResultV;
      end else if (capture) begin
        wb_tag <= pend_tag;
        if (pend_tag.wr) begin
          if (pend_tag.op == OP_SCALAR) wd_sca_dat <= scalar_output;
          else                          wd_vec_dat <= vector_output;
        end
      end
    end
  end

  assign we_sca_o  = wb_vld & wb_tag.wr & (wb_tag.op == OP_SCALAR);
  assign we_vec_o  = wb_vld & wb_tag.wr & (wb_tag.op == OP_VECTOR);
  assign wr_addr_o = wb_tag.addr;
  assign wd_sca_o  = wd_sca_dat;
  assign wd_vec_o  = wd_vec_dat;
  assign retire_o  = wb_vld;

  // timeout only redirects the FSM; no write-back entry is produced for it.
  logic unused_timeout;
  assign unused_timeout = timeout;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage; a second instance with TIMEOUT=8 covers the timeout path.
module tb_writeback_stage;

  localparam int I  = 20;
  localparam int L  = 8;
  localparam int R  = 4;
  localparam int VW = I * L;

  logic          clk = 1'b0;
  logic          rst;
  logic          valid_i, op_type, mem_read, mem_write, reg_write, mem_finished;
  logic [R-1:0]  rd_addr;
  logic [L-1:0]  aluResultS, scalar_output;
  logic [VW-1:0] aluResultV, vector_output;

  logic          stall, mem_rst, we_sca, we_vec, retire, err;
  logic [R-1:0]  wr_addr;
  logic [L-1:0]  wd_sca;
  logic [VW-1:0] wd_vec;

  logic          t_stall, t_mem_rst, t_we_sca, t_we_vec, t_retire, t_err;
  logic [R-1:0]  t_wr_addr;
  logic [L-1:0]  t_wd_sca;
  logic [VW-1:0] t_wd_vec;

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [VW-1:0] exp_vec;

  always #5 clk = ~clk;

  writeback_stage #(.I(I), .L(L), .R(R), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .op_type(op_type), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .rd_addr(rd_addr), .aluResultS(aluResultS),
    .aluResultV(aluResultV), .mem_finished(mem_finished), .scalar_output(scalar_output),
    .vector_output(vector_output), .stall_o(stall), .mem_rst_o(mem_rst), .we_sca_o(we_sca),
    .we_vec_o(we_vec), .wr_addr_o(wr_addr), .wd_sca_o(wd_sca), .wd_vec_o(wd_vec),
    .retire_o(retire), .err_o(err)
  );

  writeback_stage #(.I(I), .L(L), .R(R), .TIMEOUT(8)) dut_t (
    .clk(clk), .rst(rst), .valid_i(valid_i), .op_type(op_type), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .rd_addr(rd_addr), .aluResultS(aluResultS),
    .aluResultV(aluResultV), .mem_finished(mem_finished), .scalar_output(scalar_output),
    .vector_output(vector_output), .stall_o(t_stall), .mem_rst_o(t_mem_rst), .we_sca_o(t_we_sca),
    .we_vec_o(t_we_vec), .wr_addr_o(t_wr_addr), .wd_sca_o(t_wd_sca), .wd_vec_o(t_wd_vec),
    .retire_o(t_retire), .err_o(t_err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    valid_i   = 1'b0;
    op_type   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_write = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_in();
    rd_addr = '0; aluResultS = '0; aluResultV = '0;
    mem_finished = 1'b0; scalar_output = '0; vector_output = '0;
    tick();
    tick();
    n_cmp++;
    if ({stall, mem_rst, we_sca, we_vec, retire, err} !== 6'b0) begin
      n_bad++; $display("FAIL reset_ctl: got %b want 000000", {stall, mem_rst, we_sca, we_vec, retire, err});
    end
    n_cmp++;
    if ({wr_addr, wd_sca} !== '0) begin
      n_bad++; $display("FAIL reset_addr_sca: got %h want 0", {wr_addr, wd_sca});
    end
    n_cmp++;
    if (wd_vec !== '0) begin
      n_bad++; $display("FAIL reset_vec: got %h want 0", wd_vec);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_alu_b2b;
    logic [R-1:0] ea;
    logic [L-1:0] ed;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k > 1) begin
        ea = R'(k - 1);
        ed = L'((k - 1) * 17);
        n_cmp++;
        if ({we_sca, we_vec, retire, wr_addr, wd_sca} !== {3'b101, ea, ed}) begin
          n_bad++; $display("FAIL alu_wb%0d: got we_s=%b we_v=%b ret=%b a=%h d=%h want 1 0 1 %h %h",
                            k - 1, we_sca, we_vec, retire, wr_addr, wd_sca, ea, ed);
        end
      end
      if (k <= 3) begin
        valid_i = 1'b1; op_type = 1'b0; reg_write = 1'b1;
        rd_addr = R'(k); aluResultS = L'(k * 17);
        #1;
        n_cmp++;
        if (stall !== 1'b0) begin
          n_bad++; $display("FAIL alu_stall%0d: got %b want 0", k, stall);
        end
      end else begin
        idle_in();
      end
    end
    tick();
    n_cmp++;
    if ({we_sca, retire} !== 2'b00) begin
      n_bad++; $display("FAIL alu_drain: got we_s=%b ret=%b want 0 0", we_sca, retire);
    end
  endtask

  task automatic test_vec_load;
    tick();
    for (int k = 0; k < I; k++) begin
      vector_output[k*L +: L] = L'(k);
      exp_vec[k*L +: L] = L'(k);
    end
    aluResultV = {I{8'hAA}};
    valid_i = 1'b1; op_type = 1'b1; mem_read = 1'b1; reg_write = 1'b1;
    rd_addr = 4'd5; mem_finished = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_bad++; $display("FAIL vld_accept_stall: got %b want 1", stall);
    end
    tick();
    n_cmp++;
    if ({mem_rst, stall} !== 2'b11) begin
      n_bad++; $display("FAIL vld_restart: got mem_rst=%b stall=%b want 1 1", mem_rst, stall);
    end
    for (int c = 1; c <= 20; c++) begin
      tick();
      n_cmp++;
      if ({stall, mem_rst, we_vec} !== 3'b100) begin
        n_bad++; $display("FAIL vld_wait%0d: got stall=%b mem_rst=%b we_v=%b want 1 0 0", c, stall, mem_rst, we_vec);
      end
    end
    tick();
    mem_finished = 1'b1;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++; $display("FAIL vld_capture_stall: got %b want 0", stall);
    end
    tick();
    n_cmp++;
    if ({we_vec, we_sca, retire, wr_addr} !== {3'b101, 4'd5}) begin
      n_bad++; $display("FAIL vld_wb: got we_v=%b we_s=%b ret=%b a=%h want 1 0 1 5", we_vec, we_sca, retire, wr_addr);
    end
    n_cmp++;
    if (wd_vec !== exp_vec) begin
      n_bad++; $display("FAIL vld_data: got %h want %h", wd_vec, exp_vec);
    end
    idle_in();
    mem_finished = 1'b0;
    tick();
    n_cmp++;
    if ({we_vec, retire, mem_rst} !== 3'b000) begin
      n_bad++; $display("FAIL vld_single: got we_v=%b ret=%b mem_rst=%b want 0 0 0", we_vec, retire, mem_rst);
    end
  endtask

  task automatic test_store_alu;
    tick();
    valid_i = 1'b1; op_type = 1'b0; mem_write = 1'b1; mem_read = 1'b0; reg_write = 1'b0;
    rd_addr = 4'd7; mem_finished = 1'b0;
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_bad++; $display("FAIL st_accept_stall: got %b want 1", stall);
    end
    tick();
    n_cmp++;
    if (mem_rst !== 1'b1) begin
      n_bad++; $display("FAIL st_restart: got %b want 1", mem_rst);
    end
    tick();
    mem_finished = 1'b1;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++; $display("FAIL st_capture_stall: got %b want 0", stall);
    end
    tick();
    n_cmp++;
    if ({retire, we_sca, we_vec} !== 3'b100) begin
      n_bad++; $display("FAIL st_retire: got ret=%b we_s=%b we_v=%b want 1 0 0", retire, we_sca, we_vec);
    end
    valid_i = 1'b1; op_type = 1'b0; mem_write = 1'b0; reg_write = 1'b1;
    rd_addr = 4'd9; aluResultS = 8'h5A;
    #1;
    n_cmp++;
    if (stall !== 1'b0) begin
      n_bad++; $display("FAIL st_alu_stall: got %b want 0", stall);
    end
    tick();
    n_cmp++;
    if ({we_sca, retire, wr_addr, wd_sca} !== {2'b11, 4'd9, 8'h5A}) begin
      n_bad++; $display("FAIL st_alu_wb: got we_s=%b ret=%b a=%h d=%h want 1 1 9 5a", we_sca, retire, wr_addr, wd_sca);
    end
    idle_in();
  endtask

  task automatic test_stale_finish;
    tick();
    valid_i = 1'b1; op_type = 1'b0; mem_read = 1'b1; reg_write = 1'b1;
    rd_addr = 4'd3; scalar_output = 8'hC3; aluResultS = 8'h99;
    #1;
    n_cmp++;
    if (stall !== 1'b1) begin
      n_bad++; $display("FAIL stale_accept_stall: got %b want 1", stall);
    end
    tick();
    n_cmp++;
    if ({mem_rst, stall} !== 2'b11) begin
      n_bad++; $display("FAIL stale_ignored: got mem_rst=%b stall=%b want 1 1", mem_rst, stall);
    end
    tick();
    n_cmp++;
    if ({mem_rst, stall} !== 2'b00) begin
      n_bad++; $display("FAIL stale_capture: got mem_rst=%b stall=%b want 0 0", mem_rst, stall);
    end
    tick();
    n_cmp++;
    if ({we_sca, we_vec, wr_addr, wd_sca} !== {2'b10, 4'd3, 8'hC3}) begin
      n_bad++; $display("FAIL stale_wb: got we_s=%b we_v=%b a=%h d=%h want 1 0 3 c3", we_sca, we_vec, wr_addr, wd_sca);
    end
    n_cmp++;
    if (wd_vec !== exp_vec) begin
      n_bad++; $display("FAIL stale_vec_hold: got %h want %h", wd_vec, exp_vec);
    end
    idle_in();
    mem_finished = 1'b0;
    tick();
    n_cmp++;
    if (retire !== 1'b0) begin
      n_bad++; $display("FAIL stale_drain: got %b want 0", retire);
    end
  endtask

  task automatic test_timeout;
    int   stall_k = -1;
    int   err_k = -1;
    logic wrote = 1'b0;
    do_reset();
    n_cmp++;
    if ({t_err, err} !== 2'b00) begin
      n_bad++; $display("FAIL to_err_init: got %b want 00", {t_err, err});
    end
    tick();
    valid_i = 1'b1; op_type = 1'b1; mem_read = 1'b1; reg_write = 1'b1;
    rd_addr = 4'd4; mem_finished = 1'b0;
    for (int k = 1; k <= 40 && err_k < 0; k++) begin
      tick();
      if (t_we_sca || t_we_vec || t_retire) wrote = 1'b1;
      if (t_err && err_k < 0) err_k = k;
      #1;
      if (!t_stall && stall_k < 0) begin
        stall_k = k;
        idle_in();
      end
    end
    n_cmp++;
    if (err_k != 9) begin
      n_bad++; $display("FAIL to_err_cycle: got %0d want 9 (-1 = never)", err_k);
    end
    n_cmp++;
    if (stall_k != 8) begin
      n_bad++; $display("FAIL to_stall_drop: got %0d want 8", stall_k);
    end
    n_cmp++;
    if (wrote !== 1'b0) begin
      n_bad++; $display("FAIL to_no_write: got %b want 0", wrote);
    end
    valid_i = 1'b1; op_type = 1'b0; mem_read = 1'b0; reg_write = 1'b1;
    rd_addr = 4'd2; aluResultS = 8'h77;
    tick();
    n_cmp++;
    if ({t_we_sca, t_wr_addr, t_wd_sca, t_err, t_stall} !== {1'b1, 4'd2, 8'h77, 1'b1, 1'b0}) begin
      n_bad++; $display("FAIL to_next_op: got we_s=%b a=%h d=%h err=%b stall=%b want 1 2 77 1 0",
                        t_we_sca, t_wr_addr, t_wd_sca, t_err, t_stall);
    end
    n_cmp++;
    if (err !== 1'b0) begin
      n_bad++; $display("FAIL to_long_no_err: got %b want 0", err);
    end
    idle_in();
  endtask

  task automatic test_rst_mid;
    logic wrote = 1'b0;
    do_reset();
    tick();
    valid_i = 1'b1; op_type = 1'b1; mem_read = 1'b1; reg_write = 1'b1;
    rd_addr = 4'd6; mem_finished = 1'b0; aluResultV = {I{8'h5C}};
    tick();
    tick();
    tick();
    n_cmp++;
    if (stall !== 1'b1) begin
      n_bad++; $display("FAIL rm_waiting: got %b want 1", stall);
    end
    idle_in();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({stall, mem_rst, we_sca, we_vec, retire, err} !== 6'b0) begin
      n_bad++; $display("FAIL rm_ctl: got %b want 000000", {stall, mem_rst, we_sca, we_vec, retire, err});
    end
    n_cmp++;
    if ({wr_addr, wd_sca, wd_vec} !== '0) begin
      n_bad++; $display("FAIL rm_data: got a=%h d=%h v=%h want 0", wr_addr, wd_sca, wd_vec);
    end
    @(negedge clk);
    rst = 1'b0;
    mem_finished = 1'b1;
    repeat (6) begin
      tick();
      if (we_sca || we_vec || retire || mem_rst) wrote = 1'b1;
    end
    n_cmp++;
    if (wrote !== 1'b0) begin
      n_bad++; $display("FAIL rm_no_late_write: got %b want 0", wrote);
    end
    mem_finished = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu_b2b();
    test_vec_load();
    test_store_alu();
    test_stale_finish();
    test_timeout();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
